// File: rtl/nc_pair_buffer.sv
// Per-port staging buffer for the XOR network-coding router: queues packets with their
// address-compare vectors and presents coded pairs, or lone packets after a timeout.
module nc_pair_buffer #(
   parameter int DATA_W       = 32,
   parameter int X_W          = 2,
   parameter int Y_W          = 2,
   parameter int Z_W          = 2,
   parameter int DEPTH        = 4,
   parameter int PAIR_TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [X_W-1:0]    cur_x,
   input  logic [Y_W-1:0]    cur_y,
   input  logic [Z_W-1:0]    cur_z,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [X_W-1:0]    in_dst_x,
   input  logic [Y_W-1:0]    in_dst_y,
   input  logic [Z_W-1:0]    in_dst_z,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_coded,
   output logic [6:0]        AddrCompare_P1,
   output logic [6:0]        AddrCompare_P2,
   output logic [DATA_W-1:0] out_data_p1,
   output logic [DATA_W-1:0] out_data_p2,
   output logic [DATA_W-1:0] out_nc_data
);

   localparam int IDX_IP = 0;
   localparam int IDX_W  = 1;
   localparam int IDX_E  = 2;
   localparam int IDX_S  = 3;
   localparam int IDX_N  = 4;
   localparam int IDX_D  = 5;
   localparam int IDX_U  = 6;

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WCNT_W = $clog2(PAIR_TIMEOUT) + 1;

   typedef enum logic [1:0] {EMPTY, WAIT, OUT_PAIR, OUT_SINGLE} state_t;

   function automatic logic [6:0] addr_compare(
      input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy, input logic [Z_W-1:0] dz,
      input logic [X_W-1:0] cx, input logic [Y_W-1:0] cy, input logic [Z_W-1:0] cz
   );
      logic [6:0] v;
      v         = '0;
      v[IDX_W]  = dx < cx;
      v[IDX_E]  = dx > cx;
      v[IDX_S]  = dy < cy;
      v[IDX_N]  = dy > cy;
      v[IDX_D]  = dz < cz;
      v[IDX_U]  = dz > cz;
      v[IDX_IP] = (dx == cx) && (dy == cy) && (dz == cz);
      return v;
   endfunction

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [6:0]        mem_ac   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nx;
   logic [CNT_W-1:0]  count, pop_cnt;
   logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
   state_t            state, state_nxt;
   logic              push, load_pair, load_single;

   assign push      = in_valid & in_ready;
   assign in_ready  = (count < CNT_W'(DEPTH));
   assign out_valid = (state == OUT_PAIR) || (state == OUT_SINGLE);
   assign rd_ptr_nx = rd_ptr + PTR_W'(1);

   // Payload storage carries no reset; only pointers and count define occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= in_data;
         mem_ac[wr_ptr]   <= addr_compare(in_dst_x, in_dst_y, in_dst_z, cur_x, cur_y, cur_z);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr <= rd_ptr + pop_cnt[PTR_W-1:0];
         count  <= count + CNT_W'(push) - pop_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Pairing is checked before the timeout so a late partner still yields a coded pair.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      load_pair    = 1'b0;
      load_single  = 1'b0;
      pop_cnt      = '0;
      case (state)
         EMPTY: begin
            if (count >= CNT_W'(2)) begin
               state_nxt = OUT_PAIR;
               load_pair = 1'b1;
            end else if (count == CNT_W'(1)) begin
               state_nxt    = WAIT;
               wait_cnt_nxt = '0;
            end
         end
         WAIT: begin
            if (count >= CNT_W'(2)) begin
               state_nxt = OUT_PAIR;
               load_pair = 1'b1;
            end else if (wait_cnt == WCNT_W'(PAIR_TIMEOUT - 1)) begin
               state_nxt   = OUT_SINGLE;
               load_single = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + WCNT_W'(1);
            end
         end
         OUT_PAIR: begin
            if (out_ready) begin
               state_nxt = EMPTY;
               pop_cnt   = CNT_W'(2);
            end
         end
         OUT_SINGLE: begin
            if (out_ready) begin
               state_nxt = EMPTY;
               pop_cnt   = CNT_W'(1);
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_coded      <= 1'b0;
         AddrCompare_P1 <= '0;
         AddrCompare_P2 <= '0;
         out_data_p1    <= '0;
         out_data_p2    <= '0;
         out_nc_data    <= '0;
      end else if (load_pair) begin
         out_coded      <= 1'b1;
         AddrCompare_P1 <= mem_ac[rd_ptr];
         AddrCompare_P2 <= mem_ac[rd_ptr_nx];
         out_data_p1    <= mem_data[rd_ptr];
         out_data_p2    <= mem_data[rd_ptr_nx];
         out_nc_data    <= mem_data[rd_ptr] ^ mem_data[rd_ptr_nx];
      end else if (load_single) begin
         out_coded      <= 1'b0;
         AddrCompare_P1 <= mem_ac[rd_ptr];
         AddrCompare_P2 <= '0;
         out_data_p1    <= mem_data[rd_ptr];
         out_data_p2    <= '0;
         out_nc_data    <= mem_data[rd_ptr];
      end
   end

endmodule
